// File: rtl/conv_sched_pkg.sv
// Shared types and job-size constants for the round-robin convolution scheduler.
package conv_sched_pkg;

    localparam int X_COUNT_DEF = 64;
    localparam int F_COUNT_DEF = 33;

    // A valid (no padding) convolution yields one output per full filter overlap.
    function automatic int calc_op_count(input int x_count, input int f_count);
        return x_count - f_count + 1;
    endfunction

    localparam int OP_COUNT_DEF = calc_op_count(X_COUNT_DEF, F_COUNT_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/conv_rr_scheduler_rr_pick.sv
// Combinational round-robin select: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  grant_o,
    output logic             any_req_o
);

    int unsigned     idx_int;
    logic [ID_W-1:0] idx_sel;

    // Walk offsets from farthest to nearest so the smallest offset from ptr_i wins.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx_int   = 0;
        idx_sel   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_int = (int'(ptr_i) + k) % N_REQ;
            idx_sel = ID_W'(idx_int);
            if (req_i[idx_sel]) begin
                grant_o   = idx_sel;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_rr_scheduler.sv
// Shares one convolution engine among N_REQ stream requesters: grant, load X_COUNT
// samples, drain OP_COUNT results back to the same requester, then re-arbitrate.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are high at
// the rising clock edge; valid never waits for ready, and in LOAD/DRAIN both
// directions are pure combinational pass-throughs for the granted requester only.
module conv_rr_scheduler
    import conv_sched_pkg::*;
#(
    parameter int T       = 16,
    parameter int N_REQ   = 4,
    parameter int X_COUNT = X_COUNT_DEF,
    parameter int F_COUNT = F_COUNT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ*T-1:0]             r_data_in_x,
    input  logic [N_REQ-1:0]               r_valid_x,
    output logic [N_REQ-1:0]               r_ready_x,
    output logic [T-1:0]                   r_data_out_y,
    output logic [N_REQ-1:0]               r_valid_y,
    input  logic [N_REQ-1:0]               r_ready_y,
    output logic [T-1:0]                   e_data_in_x,
    output logic                           e_valid_x,
    input  logic                           e_ready_x,
    input  logic [T-1:0]                   e_data_out_y,
    input  logic                           e_valid_y,
    output logic                           e_ready_y,
    output logic                           busy,
    output logic [$clog2(N_REQ)-1:0]       grant_id,
    output logic [1:0]                     dbg_state
);

    localparam int OP_COUNT = calc_op_count(X_COUNT, F_COUNT);
    localparam int ID_W     = $clog2(N_REQ);
    localparam int IN_W     = $clog2(X_COUNT + 1);
    localparam int OUT_W    = $clog2(OP_COUNT + 1);

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;

    logic [ID_W-1:0]  pick_id;
    logic             any_req;
    logic             in_hs;
    logic             out_hs;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i     (r_valid_x),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_id),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        r_ready_x    = '0;
        r_valid_y    = '0;
        r_data_out_y = '0;
        e_data_in_x  = '0;
        e_valid_x    = 1'b0;
        e_ready_y    = 1'b0;
        in_hs        = 1'b0;
        out_hs       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_id;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                e_data_in_x        = r_data_in_x[int'(grant_q)*T +: T];
                e_valid_x          = r_valid_x[grant_q];
                r_ready_x[grant_q] = e_ready_x;
                in_hs              = r_valid_x[grant_q] & e_ready_x;
                if (in_hs) begin
                    if (in_cnt_q == IN_W'(X_COUNT - 1)) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Engine results before DRAIN are never forwarded; only here is e_valid_y visible.
                r_valid_y[grant_q] = e_valid_y;
                e_ready_y          = r_ready_y[grant_q];
                r_data_out_y       = e_data_out_y;
                out_hs             = e_valid_y & r_ready_y[grant_q];
                if (out_hs) begin
                    if (out_cnt_q == OUT_W'(OP_COUNT - 1)) begin
                        out_cnt_d = '0;
                        rr_ptr_d  = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + OUT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign dbg_state = state_q;

endmodule
